mem_copy_dma: RTL and testbench
===============================

Name: mem_copy_dma

Overview:
- Bus-initiator engine for the word-addressed unified memory used by the multicycle MIPS core (ports we, a, wd, rd).
- Performs word-granular block copy (memory-to-memory) or block fill (constant-to-memory) on command.
- Requests the memory port via req/gnt from the system arbiter, so it can share the port with the processor.
- Sits beside the processor and drives the memory through the same we/a/wd/rd interface.

Parameters:
LEN_W  16  width of word-count field; max transfer 2^LEN_W-1 words

Ports:
clk        input   1      system clock, all state on rising edge
reset      input   1      asynchronous, active-high reset
start      input   1      command strobe, sampled only in IDLE
mode       input   1      0 = copy, 1 = fill
src_addr   input   32     source byte address (copy only); bits [1:0] ignored
dst_addr   input   32     destination byte address; bits [1:0] ignored
len_words  input   LEN_W  number of words to transfer
fill_data  input   32     fill word (fill only)
busy       output  1      command in progress
done       output  1      one-cycle completion pulse
mem_req    output  1      request for memory port
mem_gnt    input   1      port granted this cycle
mem_we     output  1      memory write enable
mem_a      output  32     memory byte address, bits [1:0] always 00
mem_wd     output  32     memory write data
mem_rd     input   32     memory read data, combinational from mem_a

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset (async, any state): state=IDLE; busy=0, done=0, mem_req=0, mem_we=0, mem_a=0, mem_wd=0; pointers, count and data registers cleared.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On start, latch src[31:2], dst[31:2], len, mode and fill_data.
  - len==0 -> DONE (no memory access).
  - copy -> RD; fill -> WR.
  - start while not IDLE is ignored; inputs are don't-care after the latch.
- RD:
  - mem_req=1, mem_we=0, mem_a={src,2'b00}.
  - If mem_gnt: capture mem_rd into the data register, go to WR. Otherwise hold state and address.
- WR:
  - mem_req=1, mem_a={dst,2'b00}, mem_wd = data reg (copy) or latched fill_data (fill).
  - mem_we = mem_gnt (combinational). mem_we is never high without gnt or outside WR.
  - If mem_gnt: src+=1, dst+=1 (word units), remaining-=1.
  - If remaining was 1 -> DONE, else RD (copy) or WR (fill). Without gnt, hold everything.
- DONE: done=1, busy=0, mem_req=0 for exactly one cycle, then IDLE.
- busy=1 in RD and WR only.
- mem_a and mem_wd are 0 in IDLE and DONE.
- Latency with continuous gnt:
  - Copy of N words: 2N busy cycles, then the done cycle.
  - Fill of N words: N busy cycles, then done.
  - len==0: done on the cycle after start, busy never asserts.
- Each gnt-low cycle adds exactly one cycle; there is no lost or duplicated access.
- Pointers wrap modulo 2^30 words (address 0xFFFFFFFC -> 0x00000000).
- Copy proceeds in ascending order, one word at a time. Overlap with dst>src replicates the source pattern; this is defined behaviour, not an error.
- Reset mid-transfer aborts immediately. Words already written stay written; no done pulse.

Decomposition:
- Package dma_pkg:
  - typedef enum logic [1:0] dma_state_t {IDLE, RD, WR, DONE}.
  - Constants MODE_COPY=1'b0 and MODE_FILL=1'b1.
- Single module, no sub-module: one FSM plus pointer/count datapath, well under 400 lines.

Test Plan:
- Copy: memory words 0..3 = 11111111, 22222222, 33333333, 44444444; gnt=1; start copy src=0x00 dst=0x40 len=4 -> words 16..19 equal the source; busy for 8 cycles; done pulses once on cycle 9.
- Fill: fill_data=DEADBEEF, dst=0x80, len=3, gnt=1 -> words 32..34 = DEADBEEF, word 35 unchanged; busy for 3 cycles.
- Grant stall: copy len=2 with gnt toggling 1,0,1,0... -> same final memory as with gnt=1; mem_we is never high while gnt=0; busy length = 4 + number of gnt-low cycles in RD/WR.
- Edge cases: len=0 -> done on the next cycle, mem_req never asserts. src=0x03 -> treated as 0x00. start pulsed while busy -> ignored, command unchanged.
- Reset mid-copy: assert reset during the 2nd WR of a len=4 copy -> all outputs 0 asynchronously; only word dst+0 is written; no done pulse; a new start works normally afterwards.
- Wrap: fill dst=0xFFFFFFFC len=2 -> writes at 0xFFFFFFFC then 0x00000000 (bench memory with a wide enough index, or address-check only).

Source files
------------

// File: rtl/mem_copy_dma_pkg.sv
// Shared types and constants for the memory copy/fill DMA engine.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Word pointer to byte address; the low two bits are always zero.
  function automatic logic [31:0] word_to_byte(input logic [29:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Word-granular block copy / fill engine sharing the unified memory port
// with the processor through a req/gnt handshake.
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  dma_state_t       state_r;
  logic [29:0]      src_r;
  logic [29:0]      dst_r;
  logic [LEN_W-1:0] rem_r;
  logic             mode_r;
  logic [31:0]      fill_r;
  logic [31:0]      data_r;

  // Write strobe follows the grant directly so a write can never happen ungranted.
  always_comb begin
    if (state_r == WR) begin
      mem_we = mem_gnt;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Command FSM with pointer/count datapath; bus outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      src_r   <= 30'd0;
      dst_r   <= 30'd0;
      rem_r   <= '0;
      mode_r  <= MODE_COPY;
      fill_r  <= 32'd0;
      data_r  <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mem_req <= 1'b0;
      mem_a   <= 32'd0;
      mem_wd  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_r  <= src_addr[31:2];
            dst_r  <= dst_addr[31:2];
            rem_r  <= len_words;
            mode_r <= mode;
            fill_r <= fill_data;
            if (len_words == '0) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else if (mode == MODE_FILL) begin
              state_r <= WR;
              busy    <= 1'b1;
              mem_req <= 1'b1;
              mem_a   <= word_to_byte(dst_addr[31:2]);
              mem_wd  <= fill_data;
            end else begin
              state_r <= RD;
              busy    <= 1'b1;
              mem_req <= 1'b1;
              mem_a   <= word_to_byte(src_addr[31:2]);
              mem_wd  <= 32'd0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          if (mem_gnt) begin
            data_r  <= mem_rd;
            state_r <= WR;
            mem_a   <= word_to_byte(dst_r);
            mem_wd  <= mem_rd;
          end else begin
            state_r <= RD;
          end
        end
        WR: begin
          if (mem_gnt) begin
            src_r <= src_r + 30'd1;
            dst_r <= dst_r + 30'd1;
            rem_r <= rem_r - LEN_W'(1);
            if (rem_r == LEN_W'(1)) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              mem_req <= 1'b0;
              mem_a   <= 32'd0;
              mem_wd  <= 32'd0;
            end else if (mode_r == MODE_FILL) begin
              state_r <= WR;
              mem_a   <= word_to_byte(dst_r + 30'd1);
              mem_wd  <= fill_r;
            end else begin
              state_r <= RD;
              mem_a   <= word_to_byte(src_r + 30'd1);
              mem_wd  <= 32'd0;
            end
          end else begin
            state_r <= WR;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_a   <= 32'd0;
          mem_wd  <= 32'd0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          mem_req <= 1'b0;
          mem_a   <= 32'd0;
          mem_wd  <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: expected writes are queued per command
// and popped as the engine writes the bench memory.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] src_addr = 32'd0;
  logic [31:0] dst_addr = 32'd0;
  logic [15:0] len_words = 16'd0;
  logic [31:0] fill_data = 32'd0;
  logic        busy, done, mem_req, mem_we;
  logic        mem_gnt = 1'b1;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:255];
  logic [31:0] exp_mem [0:255];
  logic [63:0] sb_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int low_cnt = 0;
  int cyc = 0;
  bit toggle_gnt = 1'b0;

  mem_copy_dma #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .fill_data(fill_data), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Grant pattern: steady high, or alternating each cycle for stall tests.
  always @(posedge clk) begin
    #2;
    mem_gnt = toggle_gnt ? ~mem_gnt : 1'b1;
  end

  // Mid-cycle monitor: counts status cycles and retires each memory write against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mem_req) req_cnt++;
      if (busy && !mem_gnt) low_cnt++;
      if (mem_we) begin
        logic [63:0] e;
        check_val("we_gnt", {31'd0, mem_gnt}, 32'd1);
        check_val("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_val("wr_addr", mem_a, e[63:32]);
          check_val("wr_data", mem_wd, e[31:0]);
        end
        mem[mem_a[9:2]] = mem_wd;
      end
    end
  end

  task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] n, input logic [31:0] f);
    logic [29:0] sw, dw;
    @(negedge clk);
    busy_cnt = 0; done_cnt = 0; req_cnt = 0; low_cnt = 0;
    sw = s[31:2];
    dw = d[31:2];
    for (int i = 0; i < int'(n); i++) begin
      logic [31:0] v;
      v = (m == 1'b1) ? f : exp_mem[sw[7:0]];
      exp_mem[dw[7:0]] = v;
      sb_q.push_back({dw, 2'b00, v});
      sw = sw + 30'd1;
      dw = dw + 30'd1;
    end
    mode = m; src_addr = s; dst_addr = d; len_words = n; fill_data = f;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'b0; src_addr = 32'hFFFF_FFFF; dst_addr = 32'hFFFF_FFFF;
    len_words = 16'hFFFF; fill_data = 32'h0BAD_0BAD;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
    end
    check_val({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    @(negedge clk);
    check_val({tag, "_done_once"}, done_cnt, 32'd1);
    check_val({tag, "_q_empty"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'd0;
    end
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;
    mem[35] = 32'h1234_5678;
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = mem[i];
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_we", {31'd0, mem_we}, 32'd0);
    check_val("rst_a", mem_a, 32'd0);
    check_val("rst_wd", mem_wd, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Copy four words, continuous grant.
    issue(1'b0, 32'h0000_0000, 32'h0000_0040, 16'd4, 32'd0);
    wait_done("copy", 40);
    check_val("copy_cycles", cyc, 32'd9);
    check_val("copy_busy", busy_cnt, 32'd8);
    for (int i = 0; i < 4; i++) begin
      check_val("copy_mem", mem[16 + i], mem[i]);
    end

    // Fill three words.
    issue(1'b1, 32'h0000_0000, 32'h0000_0080, 16'd3, 32'hDEAD_BEEF);
    wait_done("fill", 40);
    check_val("fill_cycles", cyc, 32'd4);
    check_val("fill_busy", busy_cnt, 32'd3);
    for (int i = 32; i < 35; i++) begin
      check_val("fill_mem", mem[i], 32'hDEAD_BEEF);
    end
    check_val("fill_untouched", mem[35], 32'h1234_5678);

    // Copy with alternating grant.
    toggle_gnt = 1'b1;
    issue(1'b0, 32'h0000_0000, 32'h0000_0100, 16'd2, 32'd0);
    wait_done("stall", 60);
    toggle_gnt = 1'b0;
    check_val("stall_low_seen", {31'd0, low_cnt != 0}, 32'd1);
    check_val("stall_busy", busy_cnt, 32'(4 + low_cnt));
    check_val("stall_mem0", mem[64], 32'h1111_1111);
    check_val("stall_mem1", mem[65], 32'h2222_2222);

    // Zero-length command.
    issue(1'b0, 32'h0000_0000, 32'h0000_0140, 16'd0, 32'd0);
    wait_done("len0", 10);
    check_val("len0_cycles", cyc, 32'd1);
    check_val("len0_req", req_cnt, 32'd0);
    check_val("len0_busy", busy_cnt, 32'd0);

    // Unaligned source is treated as word aligned.
    issue(1'b0, 32'h0000_0003, 32'h0000_00C0, 16'd1, 32'd0);
    wait_done("unal", 20);
    check_val("unal_mem", mem[48], 32'h1111_1111);

    // Second start while busy must be ignored.
    issue(1'b0, 32'h0000_0000, 32'h0000_0200, 16'd2, 32'd0);
    @(negedge clk);
    mode = 1'b1; dst_addr = 32'h0000_0300; len_words = 16'd5; fill_data = 32'hCAFE_F00D;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", 40);
    check_val("ign_busy", busy_cnt, 32'd4);
    check_val("ign_mem", mem[192], 32'd0);

    // Reset during the second write of a four-word copy.
    issue(1'b0, 32'h0000_0000, 32'h0000_0280, 16'd4, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_req", {31'd0, mem_req}, 32'd0);
    check_val("abort_we", {31'd0, mem_we}, 32'd0);
    check_val("abort_a", mem_a, 32'd0);
    check_val("abort_wd", mem_wd, 32'd0);
    check_val("abort_pending", sb_q.size(), 32'd3);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("abort_no_done", done_cnt, 32'd0);
    check_val("abort_w0", mem[160], 32'h1111_1111);
    check_val("abort_w1", mem[161], 32'd0);
    exp_mem[161] = 32'd0; exp_mem[162] = 32'd0; exp_mem[163] = 32'd0;
    issue(1'b1, 32'h0000_0000, 32'h0000_02C0, 16'd1, 32'h5A5A_0001);
    wait_done("post", 20);
    check_val("post_mem", mem[176], 32'h5A5A_0001);

    // Destination pointer wraps past the top of the address space.
    issue(1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 16'd2, 32'hA5A5_A5A5);
    wait_done("wrap", 20);
    check_val("wrap_hi", mem[255], 32'hA5A5_A5A5);
    check_val("wrap_lo", mem[0], 32'hA5A5_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
